// File: rtl/d_pipe_pkg.sv
// Shared defaults and helpers for the d_pipe register pipeline.
package d_pipe_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 3;

  // Occupancy must be able to represent 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/d_pipe_stage.sv
// One valid/ready register stage: holds its slot while stalled, otherwise loads
// from upstream and clears when an empty slot arrives.
module d_pipe_stage
  import d_pipe_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             dn_ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             ready
);

  // An empty stage always accepts, which is what squeezes bubbles out.
  assign ready = ~valid | dn_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (ready) begin
      valid <= up_valid;
      if (up_valid) begin
        data <= up_data;
      end
    end
  end

endmodule

// File: rtl/d_pipe_asyn_rstn.sv
// DEPTH-stage valid/ready D-register pipeline with bubble collapse, flush and
// a registered occupancy count.
module d_pipe_asyn_rstn
  import d_pipe_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int CNT_W = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] occupancy
);

  logic accept;
  logic emit;

  // Each block owns its own wires so the backward ready chain stays per-stage.
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;
    logic             up_valid;
    logic [WIDTH-1:0] up_data;
    logic             dn_ready;

    if (i == 0) begin : g_head
      assign up_valid = in_valid;
      assign up_data  = in_data;
    end else begin : g_body
      assign up_valid = g_stage[i-1].valid;
      assign up_data  = g_stage[i-1].data;
    end

    if (i == DEPTH - 1) begin : g_tail
      assign dn_ready = out_ready;
    end else begin : g_link
      assign dn_ready = g_stage[i+1].ready;
    end

    d_pipe_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk     (clk),
      .reset_n (reset_n),
      .flush   (flush),
      .up_valid(up_valid),
      .up_data (up_data),
      .dn_ready(dn_ready),
      .valid   (valid),
      .data    (data),
      .ready   (ready)
    );
  end

  assign in_ready  = g_stage[0].ready & ~flush & reset_n;
  assign out_valid = g_stage[DEPTH-1].valid;
  assign out_data  = g_stage[DEPTH-1].data;

  assign accept = in_valid & in_ready;
  assign emit   = out_valid & out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      occupancy <= '0;
    end else if (flush) begin
      occupancy <= '0;
    end else begin
      occupancy <= occupancy + CNT_W'(accept) - CNT_W'(emit);
    end
  end

endmodule

// File: tb/tb_d_pipe_asyn_rstn.sv
// Self-checking bench for d_pipe_asyn_rstn: scripted scenarios plus random
// traffic, all compared against a queue-of-items position model.
module tb_d_pipe_asyn_rstn;

  localparam int WIDTH = 8;
  localparam int DEPTH = 3;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic             v;
    logic [WIDTH-1:0] d;
    logic             r;
    logic             f;
  } stim_t;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             out_ready = 1'b0;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] occupancy;

  int checks = 0;
  int errors = 0;

  // Model: items in arrival order (oldest first) with their stage position.
  int               m_pos[$];
  logic [WIDTH-1:0] m_dat[$];

  d_pipe_asyn_rstn #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  function automatic logic exp_in_ready();
    return reset_n && !flush && ((m_pos.size() < DEPTH) || out_ready);
  endfunction

  function automatic logic exp_out_valid();
    return (m_pos.size() > 0) && (m_pos[0] == DEPTH - 1);
  endfunction

  function automatic stim_t mk(input logic v, input logic [WIDTH-1:0] d,
                               input logic r, input logic f);
    stim_t s;
    s.v = v;
    s.d = d;
    s.r = r;
    s.f = f;
    return s;
  endfunction

  // Items move forward whenever the slot ahead is (or becomes) free.
  always @(posedge clk or negedge reset_n) begin : model
    bit acc;
    int lim;
    if (!reset_n) begin
      m_pos.delete();
      m_dat.delete();
    end else if (flush) begin
      m_pos.delete();
      m_dat.delete();
    end else begin
      acc = in_valid && exp_in_ready();
      if (exp_out_valid() && out_ready) begin
        void'(m_pos.pop_front());
        void'(m_dat.pop_front());
      end
      for (int k = 0; k < m_pos.size(); k++) begin
        lim = (k == 0) ? DEPTH - 1 : m_pos[k-1] - 1;
        if (m_pos[k] < lim) m_pos[k] = m_pos[k] + 1;
      end
      if (acc) begin
        m_pos.push_back(0);
        m_dat.push_back(in_data);
      end
    end
  end

  task automatic drive(input stim_t s);
    in_valid  = s.v;
    in_data   = s.d;
    out_ready = s.r;
    flush     = s.f;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive(mk(1'b1, 8'hA5, 1'b1, 1'b0));
    repeat (3) begin
      @(negedge clk);
      #1;
      checks += 4;
      if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset out_valid: got %b want 0", out_valid); end
      if (out_data !== '0) begin errors++; $display("[TB] FAIL reset out_data: got %h want 00", out_data); end
      if (occupancy !== '0) begin errors++; $display("[TB] FAIL reset occupancy: got %0d want 0", occupancy); end
      if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset in_ready: got %b want 0", in_ready); end
    end
    @(negedge clk);
    drive(mk(1'b0, 8'h00, 1'b1, 1'b0));
    reset_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL release in_ready: got %b want 1", in_ready); end
    drive(mk(1'b1, 8'h3C, 1'b1, 1'b0));
    @(negedge clk);
    drive(mk(1'b0, 8'h00, 1'b1, 1'b0));
    #1;
    checks++;
    if (occupancy !== CNT_W'(1)) begin errors++; $display("[TB] FAIL first_accept occupancy: got %0d want 1", occupancy); end
    repeat (DEPTH + 1) @(negedge clk);
  endtask

  task automatic test_stream();
    stim_t s[$];
    logic [WIDTH-1:0] exp_next = 8'h01;
    for (int i = 1; i <= 10; i++) s.push_back(mk(1'b1, WIDTH'(i), 1'b1, 1'b0));
    repeat (5) s.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0));
    foreach (s[c]) begin
      @(negedge clk);
      drive(s[c]);
      #1;
      checks += 3;
      if (in_ready !== exp_in_ready()) begin errors++; $display("[TB] FAIL stream in_ready cyc %0d: got %b want %b", c, in_ready, exp_in_ready()); end
      if (out_valid !== exp_out_valid()) begin errors++; $display("[TB] FAIL stream out_valid cyc %0d: got %b want %b", c, out_valid, exp_out_valid()); end
      if (occupancy !== CNT_W'(m_pos.size())) begin errors++; $display("[TB] FAIL stream occupancy cyc %0d: got %0d want %0d", c, occupancy, m_pos.size()); end
      if (exp_out_valid()) begin
        checks++;
        if (out_data !== m_dat[0]) begin errors++; $display("[TB] FAIL stream out_data cyc %0d: got %h want %h", c, out_data, m_dat[0]); end
      end
      if (c == 2) begin
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL stream early_valid: got %b want 0", out_valid); end
      end
      if (c == 6) begin
        checks++;
        if (occupancy !== CNT_W'(DEPTH)) begin errors++; $display("[TB] FAIL stream steady_occupancy: got %0d want %0d", occupancy, DEPTH); end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (out_data !== exp_next) begin errors++; $display("[TB] FAIL stream order: got %h want %h", out_data, exp_next); end
        exp_next++;
      end
    end
    checks++;
    if (exp_next !== 8'h0B) begin errors++; $display("[TB] FAIL stream delivered: got %0d want 10", exp_next - 1); end
  endtask

  task automatic test_backpressure();
    stim_t s[$];
    s.push_back(mk(1'b1, 8'h11, 1'b0, 1'b0));
    s.push_back(mk(1'b1, 8'h22, 1'b0, 1'b0));
    s.push_back(mk(1'b1, 8'h33, 1'b0, 1'b0));
    s.push_back(mk(1'b1, 8'h44, 1'b0, 1'b0));
    s.push_back(mk(1'b1, 8'h44, 1'b1, 1'b0));
    repeat (5) s.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0));
    foreach (s[c]) begin
      @(negedge clk);
      drive(s[c]);
      #1;
      checks += 3;
      if (in_ready !== exp_in_ready()) begin errors++; $display("[TB] FAIL bp in_ready cyc %0d: got %b want %b", c, in_ready, exp_in_ready()); end
      if (out_valid !== exp_out_valid()) begin errors++; $display("[TB] FAIL bp out_valid cyc %0d: got %b want %b", c, out_valid, exp_out_valid()); end
      if (occupancy !== CNT_W'(m_pos.size())) begin errors++; $display("[TB] FAIL bp occupancy cyc %0d: got %0d want %0d", c, occupancy, m_pos.size()); end
      if (exp_out_valid()) begin
        checks++;
        if (out_data !== m_dat[0]) begin errors++; $display("[TB] FAIL bp out_data cyc %0d: got %h want %h", c, out_data, m_dat[0]); end
      end
      if (c == 3) begin
        checks += 3;
        if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp full_in_ready: got %b want 0", in_ready); end
        if (occupancy !== CNT_W'(3)) begin errors++; $display("[TB] FAIL bp full_occupancy: got %0d want 3", occupancy); end
        if (out_data !== 8'h11) begin errors++; $display("[TB] FAIL bp head_data: got %h want 11", out_data); end
      end
      if (c == 4) begin
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp pass_in_ready: got %b want 1", in_ready); end
      end
      if (c == 5) begin
        checks += 2;
        if (occupancy !== CNT_W'(3)) begin errors++; $display("[TB] FAIL bp pass_occupancy: got %0d want 3", occupancy); end
        if (out_data !== 8'h22) begin errors++; $display("[TB] FAIL bp next_head: got %h want 22", out_data); end
      end
    end
  endtask

  task automatic test_bubble();
    stim_t s[$];
    s.push_back(mk(1'b1, 8'h55, 1'b0, 1'b0));
    s.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0));
    s.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0));
    s.push_back(mk(1'b1, 8'h66, 1'b0, 1'b0));
    s.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0));
    repeat (5) s.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0));
    foreach (s[c]) begin
      @(negedge clk);
      drive(s[c]);
      #1;
      checks += 3;
      if (in_ready !== exp_in_ready()) begin errors++; $display("[TB] FAIL bubble in_ready cyc %0d: got %b want %b", c, in_ready, exp_in_ready()); end
      if (out_valid !== exp_out_valid()) begin errors++; $display("[TB] FAIL bubble out_valid cyc %0d: got %b want %b", c, out_valid, exp_out_valid()); end
      if (occupancy !== CNT_W'(m_pos.size())) begin errors++; $display("[TB] FAIL bubble occupancy cyc %0d: got %0d want %0d", c, occupancy, m_pos.size()); end
      if (exp_out_valid()) begin
        checks++;
        if (out_data !== m_dat[0]) begin errors++; $display("[TB] FAIL bubble out_data cyc %0d: got %h want %h", c, out_data, m_dat[0]); end
      end
      if (c == 5) begin
        checks += 2;
        if (occupancy !== CNT_W'(2)) begin errors++; $display("[TB] FAIL bubble squeezed_occupancy: got %0d want 2", occupancy); end
        if (out_data !== 8'h55) begin errors++; $display("[TB] FAIL bubble first_out: got %h want 55", out_data); end
      end
      if (c == 6) begin
        checks++;
        if (!(out_valid === 1'b1 && out_data === 8'h66)) begin errors++; $display("[TB] FAIL bubble back_to_back: got %b/%h want 1/66", out_valid, out_data); end
      end
    end
  endtask

  task automatic test_flush();
    stim_t s[$];
    s.push_back(mk(1'b1, 8'hA1, 1'b0, 1'b0));
    s.push_back(mk(1'b1, 8'hA2, 1'b0, 1'b0));
    s.push_back(mk(1'b1, 8'hA3, 1'b0, 1'b0));
    s.push_back(mk(1'b1, 8'h99, 1'b0, 1'b1));
    s.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0));
    s.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0));
    foreach (s[c]) begin
      @(negedge clk);
      drive(s[c]);
      #1;
      checks += 3;
      if (in_ready !== exp_in_ready()) begin errors++; $display("[TB] FAIL flush in_ready cyc %0d: got %b want %b", c, in_ready, exp_in_ready()); end
      if (out_valid !== exp_out_valid()) begin errors++; $display("[TB] FAIL flush out_valid cyc %0d: got %b want %b", c, out_valid, exp_out_valid()); end
      if (occupancy !== CNT_W'(m_pos.size())) begin errors++; $display("[TB] FAIL flush occupancy cyc %0d: got %0d want %0d", c, occupancy, m_pos.size()); end
      if (c == 3) begin
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL flush cycle_in_ready: got %b want 0", in_ready); end
      end
      if (c == 4 || c == 5) begin
        checks += 2;
        if (occupancy !== '0) begin errors++; $display("[TB] FAIL flush cleared_occupancy cyc %0d: got %0d want 0", c, occupancy); end
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush cleared_valid cyc %0d: got %b want 0", c, out_valid); end
      end
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    drive(mk(1'b1, 8'hB1, 1'b0, 1'b0));
    @(negedge clk);
    drive(mk(1'b1, 8'hB2, 1'b0, 1'b0));
    @(negedge clk);
    drive(mk(1'b0, 8'h00, 1'b0, 1'b0));
    @(negedge clk);
    #1;
    checks += 2;
    if (occupancy !== CNT_W'(2)) begin errors++; $display("[TB] FAIL areset inflight_occupancy: got %0d want 2", occupancy); end
    if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL areset inflight_valid: got %b want 1", out_valid); end
    reset_n = 1'b0;
    #1;
    checks += 3;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL areset out_valid: got %b want 0", out_valid); end
    if (occupancy !== '0) begin errors++; $display("[TB] FAIL areset occupancy: got %0d want 0", occupancy); end
    if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL areset in_ready: got %b want 0", in_ready); end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      drive(mk(($urandom % 4) != 0, WIDTH'($urandom), ($urandom % 3) != 0, ($urandom % 25) == 0));
      #1;
      checks += 3;
      if (in_ready !== exp_in_ready()) begin errors++; $display("[TB] FAIL random in_ready cyc %0d: got %b want %b", c, in_ready, exp_in_ready()); end
      if (out_valid !== exp_out_valid()) begin errors++; $display("[TB] FAIL random out_valid cyc %0d: got %b want %b", c, out_valid, exp_out_valid()); end
      if (occupancy !== CNT_W'(m_pos.size())) begin errors++; $display("[TB] FAIL random occupancy cyc %0d: got %0d want %0d", c, occupancy, m_pos.size()); end
      if (exp_out_valid()) begin
        checks++;
        if (out_data !== m_dat[0]) begin errors++; $display("[TB] FAIL random out_data cyc %0d: got %h want %h", c, out_data, m_dat[0]); end
      end
    end
    @(negedge clk);
    drive(mk(1'b0, 8'h00, 1'b1, 1'b0));
    repeat (DEPTH + 1) @(negedge clk);
  endtask

  initial begin
    $display("[TB] d_pipe_asyn_rstn WIDTH=%0d DEPTH=%0d", WIDTH, DEPTH);
    test_reset();
    test_stream();
    test_backpressure();
    test_bubble();
    test_flush();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/d_pipe_asyn_rstn.md
Name: d_pipe_asyn_rstn

Overview:
Parametrised D-register pipeline with a valid/ready handshake. It carries WIDTH-bit data through DEPTH register stages. Stalls backpressure stage by stage and collapse bubbles, so an empty stage always accepts new data. It is the general successor to the single-bit D storage element and serves as the standard retiming and buffering stage between datapath blocks.

Parameters:
WIDTH, 8, data width in bits (>=1)
DEPTH, 3, number of register stages (>=1); equals both latency and capacity
CNT_W, $clog2(DEPTH+1), width of the occupancy count (derived, not to be overridden)

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
flush  input  1  synchronous clear of all stage valids
in_valid  input  1  upstream data valid
in_ready  output  1  pipeline can accept in_data this cycle
in_data  input  WIDTH  upstream data
out_valid  output  1  last stage holds valid data
out_ready  input  1  downstream accepts out_data
out_data  output  WIDTH  last-stage data
occupancy  output  CNT_W  number of valid stages, 0..DEPTH

Behaviour:
- Reset (reset_n=0, asynchronous): all stage valid=0, all stage data=0, occupancy=0, out_valid=0, out_data=0. in_ready=0 while reset_n=0. Release is synchronous to clk; the first accept is possible on the first edge after deassertion.
- Per stage i (0=input side, DEPTH-1=output side):
  - ready_i = ~valid_i | ready_{i+1}, with ready_DEPTH = out_ready. This is a combinational backward chain; in_ready = ready_0 & ~flush.
  - Stage i loads when ready_i is 1: valid_i <= valid_{i-1} (in_valid for i=0) and data_i <= data_{i-1} (in_data for i=0).
  - Data loads only when the incoming valid is 1. A stage receiving an empty slot clears valid_i and holds its old data.
  - When ready_i is 0, the stage holds valid and data unchanged.
- Handshake:
  - Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
  - out_valid/out_data do not depend combinationally on out_ready.
  - Once out_valid=1, out_data is stable until the transfer out.
- Latency and throughput:
  - Empty pipe, no stall: data accepted at edge N is on out_data after edge N+DEPTH-1, so the first out_valid appears DEPTH-1 cycles after the accept edge. Data sits in stage 0 after the accept edge.
  - Throughput is 1 transfer per cycle with out_ready held at 1.
- Bubble collapse: with out_ready=0, an upstream bubble is squeezed out. A full pipe holds exactly DEPTH items, and in_ready=0 only when all stages are valid and out_ready=0.
- Simultaneous events:
  - Full pipe with out_ready=1 and in_valid=1: accept and emit in the same cycle; occupancy is unchanged.
  - flush=1 overrides everything. All valid <= 0 at the next edge, and in_ready=0 that cycle, so no accept occurs.
  - Under flush, an out_valid/out_ready transfer in the same cycle still counts as delivered; downstream sees the data.
  - Data registers are not cleared by flush.
- occupancy: registered. Next value = current + accept - emit, or 0 on flush. It never exceeds DEPTH and never underflows.
- Reset mid-stream: everything is discarded immediately (asynchronous) and no transfers are reported.
- DEPTH=1: a single registered stage with in_ready = ~valid | out_ready.

Decomposition:
- Package d_pipe_pkg: default WIDTH/DEPTH localparams and a function cnt_width(depth) returning $clog2(depth+1).
- Sub-module d_pipe_stage (params WIDTH):
  - inputs: clk, reset_n, flush, up_valid, up_data, dn_ready
  - outputs: valid, data, ready
  - contains one stage's register and the ready equation.
- The top level instantiates DEPTH d_pipe_stage instances in a generate loop and adds the occupancy counter.

Test Plan:
- Reset: hold reset_n=0 with in_valid=1, in_data=8'hA5 -> out_valid=0, out_data=0, occupancy=0, in_ready=0. Deassert -> in_ready=1 at the next edge.
- Streaming (WIDTH=8, DEPTH=3, out_ready=1): push 8'h01..8'h0A on consecutive cycles -> 8'h01 appears 2 cycles after its accept edge, one item per cycle in order, occupancy settles at 3.
- Full/backpressure: out_ready=0, push 8'h11,8'h22,8'h33,8'h44 -> three accepted, in_ready=0 on the 4th, occupancy=3, out_data=8'h11 stable. Raise out_ready -> 8'h44 accepted in the same cycle 8'h11 leaves.
- Bubble collapse: push 8'h55, idle 2 cycles, push 8'h66 with out_ready=0 -> occupancy=2 and both items drain back-to-back once out_ready=1.
- Flush: pipe holding 3 items with flush=1 for one cycle -> occupancy=0, out_valid=0 next cycle, in_ready=0 during the flush cycle, and the in_valid item that cycle is not accepted.
- Async reset mid-stream: drop reset_n between clock edges with 2 items in flight -> out_valid and occupancy go to 0 immediately, without waiting for clk.
